writeback_tracker: RTL and testbench
====================================

# writeback_tracker

Producer side of the pipelined core's forwarding interface. Records the destination-register information of every instruction leaving decode and shifts it through three slots: EX (prev1), MEM (prev2) and WB (prev3). These slots drive the `prev*_write`, `prev*_write_addr` and `prev*_mem` inputs of the forwarding unit. The block inserts bubbles on load-use stalls and flushes, freezes on a global hold, and keeps retire/stall/flush event counters.

## Interface
Parameters:
- `COUNT_W`, 32, width of each event counter

Ports:
- `clk`  in  1  core clock
- `reset`  in  1  synchronous, active-high
- `hold`  in  1  global freeze (memory not ready); all state holds
- `flush`  in  1  squash the decode-stage instruction (branch redirect)
- `stall`  in  1  load-use stall from forwarding (`skip_instr`); insert bubble
- `id_valid`  in  1  decode stage holds a real instruction
- `id_rd_addr`  in  5  destination register of decode instruction
- `id_write`  in  1  decode instruction writes rd
- `id_mem`  in  1  decode instruction is a load (rd value comes from memory)
- `prev1_write`, `prev2_write`, `prev3_write`  out  1 each  slot writes a register
- `prev1_write_addr`, `prev2_write_addr`, `prev3_write_addr`  out  5 each  slot destination
- `prev1_mem`, `prev2_mem`, `prev3_mem`  out  1 each  slot value comes from memory
- `retire_count`  out  COUNT_W  valid instructions that left slot 3
- `stall_count`  out  COUNT_W  bubbles inserted due to `stall`
- `flush_count`  out  COUNT_W  instructions squashed by `flush`

## Operation
- Each slot holds `{valid, write, addr[4:0], mem}`. A bubble is all-zero.
- Capture into slot 1 on every cycle with `hold`=0. Priority is `flush` > `stall` > normal:
  - `flush`=1: slot 1 takes a bubble. `flush_count`++ if `id_valid`.
  - else `stall`=1: slot 1 takes a bubble. `stall_count`++ if `id_valid`.
  - else `id_valid`=1: slot 1 takes `valid`=1, `addr`=`id_rd_addr`, `write`=`id_write && id_rd_addr!=0`, `mem`=`id_mem && write`.
  - else: slot 1 takes a bubble.
- In the same cycle, slot 2 takes slot 1 and slot 3 takes slot 2. Slot 3's old content retires; `retire_count`++ if its `valid`=1.
- `hold`=1 overrides everything: slots and counters keep their values, and `flush`/`stall` are ignored that cycle. Upstream re-presents them.
- `prev1_*` outputs = slot 1 fields; likewise for 2 and 3. `valid` is internal only.
- A write to x0 never produces `write`=1 or `mem`=1. A load to x0 therefore never causes a stall.
- Counters wrap modulo 2^COUNT_W without saturation.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs. This is required because `stall` is computed from `prev1_*`, and a combinational path would form a loop.
- Reset values: all slots are bubbles, so every `prev*` output is 0. All counters are 0.
- Latency: decode inputs appear on `prev1_*` 1 cycle after capture, on `prev2_*` after 2 cycles, and on `prev3_*` after 3 cycles. The instruction retires (counted) at the 4th edge.
- With no hold and no squash, throughput is one instruction per cycle.
- `reset` asserted mid-operation clears all slots and counters at the next edge and overrides `hold`.
- `flush` and `stall` together count only in `flush_count`.

## Structure
- Shared `pipeline_pkg` contents:
  - typedef `wb_slot_t` (`valid`, `write`, `addr`, `mem`)
  - constant `WB_BUBBLE`
  - `REG_ADDR_W`=5
  - `REG_ZERO`=5'd0
- One sub-module, `event_counter` (COUNT_W-wide, synchronous reset, `inc` and `en` inputs), instantiated three times.
- Slot shift and capture priority live in the top module.

## Test plan
- Reset then idle: all `prev*` and counters are 0. Present `id_valid`=1, rd=5, write=1, mem=0. Expect `prev1_write_addr`=5 and `prev1_write`=1 after 1 cycle, `prev2` after 2, `prev3` after 3, and `retire_count`=1 after 4.
- Load to rd=7 followed by `stall` pulsed 1 cycle. Expect `prev1_mem`=1 for the load, then `prev1_write`=0 the next cycle (bubble), `stall_count`=1, and the load on `prev2_mem`=1.
- rd=0 with write=1 and mem=1: all `prev1` outputs stay 0 except that `retire_count` still increments after 4 cycles.
- `flush` and `stall` both high with `id_valid`=1: expect a bubble, `flush_count`=1 and `stall_count`=0.
- Fill the slots with rd=1,2,3, then hold for 5 cycles while toggling `flush`/`stall`: outputs stay 1,2,3 and all counters are unchanged. Release: normal shifting resumes.
- Preload `retire_count` near 2^COUNT_W−1 (COUNT_W=4, 16 retires): the count wraps to 0. Reset asserted while `hold`=1 clears everything.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: the writeback slot record and register-file constants.
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic [REG_ADDR_W-1:0] addr;
        logic                  mem;
    } wb_slot_t;

    localparam wb_slot_t WB_BUBBLE = '0;

    // Builds the slot for a real decode instruction; x0 is never a write target.
    function automatic wb_slot_t make_slot(
        input logic [REG_ADDR_W-1:0] rd,
        input logic                  wr,
        input logic                  ld
    );
        wb_slot_t s;
        s.valid = 1'b1;
        s.addr  = rd;
        s.write = wr && (rd != REG_ZERO);
        s.mem   = ld && s.write;
        return s;
    endfunction

endpackage

// File: rtl/event_counter.sv
// Wrapping event counter: counts cycles with en and inc both high.
module event_counter #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (en && inc)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/writeback_tracker.sv
// Tracks destination-register info of instructions through EX/MEM/WB slots
// for the forwarding unit, with bubble insertion, global hold and event counters.
module writeback_tracker
    import pipeline_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  stall,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_write,
    input  logic                  id_mem,
    output logic                  prev1_write,
    output logic                  prev2_write,
    output logic                  prev3_write,
    output logic [REG_ADDR_W-1:0] prev1_write_addr,
    output logic [REG_ADDR_W-1:0] prev2_write_addr,
    output logic [REG_ADDR_W-1:0] prev3_write_addr,
    output logic                  prev1_mem,
    output logic                  prev2_mem,
    output logic                  prev3_mem,
    output logic [COUNT_W-1:0]    retire_count,
    output logic [COUNT_W-1:0]    stall_count,
    output logic [COUNT_W-1:0]    flush_count
);

    wb_slot_t slot1, slot2, slot3;
    wb_slot_t slot1_next;
    logic     advance;

    assign advance = !hold;

    always_comb begin
        slot1_next = WB_BUBBLE;
        if (!flush && !stall && id_valid)
            slot1_next = make_slot(id_rd_addr, id_write, id_mem);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot1 <= WB_BUBBLE;
            slot2 <= WB_BUBBLE;
            slot3 <= WB_BUBBLE;
        end else if (advance) begin
            slot1 <= slot1_next;
            slot2 <= slot1;
            slot3 <= slot2;
        end
    end

    // Outputs come straight from slot registers so stall (derived from prev1) cannot loop.
    assign prev1_write      = slot1.write;
    assign prev1_write_addr = slot1.addr;
    assign prev1_mem        = slot1.mem;
    assign prev2_write      = slot2.write;
    assign prev2_write_addr = slot2.addr;
    assign prev2_mem        = slot2.mem;
    assign prev3_write      = slot3.write;
    assign prev3_write_addr = slot3.addr;
    assign prev3_mem        = slot3.mem;

    event_counter #(.COUNT_W(COUNT_W)) u_retire_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .inc   (slot3.valid),
        .count (retire_count)
    );

    event_counter #(.COUNT_W(COUNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .inc   (stall && !flush && id_valid),
        .count (stall_count)
    );

    event_counter #(.COUNT_W(COUNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .inc   (flush && id_valid),
        .count (flush_count)
    );

endmodule

// File: tb/tb_writeback_tracker.sv
// Randomized and directed bench for writeback_tracker against a history-queue model.
module tb_writeback_tracker;

    localparam int CW  = 4;
    localparam int MOD = 1 << CW;

    logic          clk = 1'b0;
    logic          reset, hold, flush, stall, id_valid, id_write, id_mem;
    logic [4:0]    id_rd_addr;
    logic          p1w, p2w, p3w, p1m, p2m, p3m;
    logic [4:0]    p1a, p2a, p3a;
    logic [CW-1:0] rc, sc, fc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit       v;
        bit       w;
        bit [4:0] a;
        bit       m;
    } ent_t;

    // hist[k] is what entered the pipe k advancing cycles ago, i.e. prev(k+1).
    ent_t hist[$];
    int   m_rc, m_sc, m_fc;

    always #5 clk = ~clk;

    writeback_tracker #(.COUNT_W(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .hold             (hold),
        .flush            (flush),
        .stall            (stall),
        .id_valid         (id_valid),
        .id_rd_addr       (id_rd_addr),
        .id_write         (id_write),
        .id_mem           (id_mem),
        .prev1_write      (p1w),
        .prev2_write      (p2w),
        .prev3_write      (p3w),
        .prev1_write_addr (p1a),
        .prev2_write_addr (p2a),
        .prev3_write_addr (p3a),
        .prev1_mem        (p1m),
        .prev2_mem        (p2m),
        .prev3_mem        (p3m),
        .retire_count     (rc),
        .stall_count      (sc),
        .flush_count      (fc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ent_t z;
        z = '{v: 0, w: 0, a: 0, m: 0};
        hist.delete();
        repeat (3) hist.push_back(z);
        m_rc = 0;
        m_sc = 0;
        m_fc = 0;
    endtask

    task automatic model_edge();
        ent_t e;
        e = '{v: 0, w: 0, a: 0, m: 0};
        if (reset) begin
            model_reset();
        end else if (!hold) begin
            if (hist[2].v) m_rc = (m_rc + 1) % MOD;
            if (flush) begin
                if (id_valid) m_fc = (m_fc + 1) % MOD;
            end else if (stall) begin
                if (id_valid) m_sc = (m_sc + 1) % MOD;
            end else if (id_valid) begin
                e.v = 1;
                e.a = id_rd_addr;
                e.w = id_write && (id_rd_addr != 0);
                e.m = id_mem && e.w;
            end
            hist.push_front(e);
            void'(hist.pop_back());
        end
    endtask

    task automatic check_model();
        chk("p1_write", p1w, hist[0].w);
        chk("p1_addr",  p1a, hist[0].a);
        chk("p1_mem",   p1m, hist[0].m);
        chk("p2_write", p2w, hist[1].w);
        chk("p2_addr",  p2a, hist[1].a);
        chk("p2_mem",   p2m, hist[1].m);
        chk("p3_write", p3w, hist[2].w);
        chk("p3_addr",  p3a, hist[2].a);
        chk("p3_mem",   p3m, hist[2].m);
        chk("retire_cnt", rc, m_rc);
        chk("stall_cnt",  sc, m_sc);
        chk("flush_cnt",  fc, m_fc);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic w, input logic m);
        id_valid   = v;
        id_rd_addr = rd;
        id_write   = w;
        id_mem     = m;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        reset = 1; hold = 0; flush = 0; stall = 0;
        set_id(0, 0, 0, 0);
        model_reset();
        tick();
        tick();
        reset = 0;
        tick();
        chk("rst_p1_write", p1w, 0);
        chk("rst_p3_addr",  p3a, 0);
        chk("rst_retire",   rc,  0);

        // Basic latency through the three slots
        set_id(1, 5, 1, 0);
        tick();
        chk("lat_p1_addr",  p1a, 5);
        chk("lat_p1_write", p1w, 1);
        set_id(0, 0, 0, 0);
        tick();
        chk("lat_p2_addr", p2a, 5);
        tick();
        chk("lat_p3_addr", p3a, 5);
        tick();
        chk("lat_retire", rc, 1);

        // Load then a one-cycle load-use stall
        do_reset();
        set_id(1, 7, 1, 1);
        tick();
        chk("ld_p1_mem", p1m, 1);
        set_id(1, 9, 1, 0);
        stall = 1;
        tick();
        stall = 0;
        chk("stall_bubble", p1w, 0);
        chk("stall_count",  sc,  1);
        chk("ld_p2_mem",    p2m, 1);
        set_id(0, 0, 0, 0);
        tick();

        // Write/load to x0 never marks a write, but still retires
        do_reset();
        set_id(1, 0, 1, 1);
        tick();
        chk("x0_p1_write", p1w, 0);
        chk("x0_p1_mem",   p1m, 0);
        set_id(0, 0, 0, 0);
        repeat (3) tick();
        chk("x0_retire", rc, 1);

        // flush beats stall
        do_reset();
        set_id(1, 4, 1, 0);
        flush = 1; stall = 1;
        tick();
        flush = 0; stall = 0;
        chk("fs_bubble", p1w, 0);
        chk("fs_flush",  fc,  1);
        chk("fs_stall",  sc,  0);

        // Hold freezes slots and counters despite flush/stall activity
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            set_id(1, 5'(i), 1, 0);
            tick();
        end
        hold = 1;
        for (int i = 0; i < 5; i++) begin
            flush = i[0];
            stall = i[1];
            set_id(1, 5'(20 + i), 1, 1);
            tick();
            chk("hold_p1", p1a, 3);
            chk("hold_p2", p2a, 2);
            chk("hold_p3", p3a, 1);
            chk("hold_rc", rc,  0);
        end
        hold = 0; flush = 0; stall = 0;
        set_id(0, 0, 0, 0);
        tick();
        chk("rel_p2", p2a, 3);
        chk("rel_p3", p3a, 2);
        chk("rel_rc", rc,  1);

        // retire_count wraps after 2^CW retirements
        do_reset();
        for (int i = 0; i < MOD; i++) begin
            set_id(1, 5'($urandom_range(1, 31)), 1, 0);
            tick();
        end
        set_id(0, 0, 0, 0);
        tick();
        tick();
        chk("wrap_pre", rc, MOD - 1);
        tick();
        chk("wrap_zero", rc, 0);

        // Reset overrides hold
        set_id(1, 6, 1, 1);
        tick();
        hold = 1; reset = 1;
        tick();
        chk("rsthold_p1", p1a, 0);
        chk("rsthold_rc", rc,  0);
        hold = 0; reset = 0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            hold  = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 5) == 0);
            set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                   1'($urandom), 1'($urandom));
            if ($urandom_range(0, 7) == 0) id_rd_addr = 5'd0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
